// File: rtl/atanh_fp16_pipe.sv
// rtl/atanh_fp16_pipe.sv - pipelined FP16 atanh(x), |x| < 1
// Four enabled stages: capture, classify/address + ROM read, normalize, output.
module atanh_fp16_pipe #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        in_valid,
  input  logic [15:0] num_entrada,
  output logic        out_valid,
  output logic [15:0] num_salida
);

  localparam int      FRAC = 28;
  localparam longint  ONE  = longint'(1) <<< FRAC;
  localparam longint  LN2  = 186065280;  // ln(2) * 2^28

  // ln(v) * 2^28 for integer v >= 1: power-of-two split, then ln(f) = 2*atanh((f-1)/(f+1)).
  function automatic longint ln_fx(input longint v);
    longint f, z, z2, t, sum;
    int     k;
    k = 0;
    for (int i = 1; i < 14; i++) begin
      if ((v >>> i) != 0) k = i;
    end
    f   = (v <<< FRAC) >>> k;
    z   = ((f - ONE) <<< FRAC) / (f + ONE);
    z2  = (z * z) >>> FRAC;
    t   = z;
    sum = z;
    for (int i = 1; i < 16; i++) begin
      t   = (t * z2) >>> FRAC;
      sum = sum + t / longint'(2 * i + 1);
    end
    return longint'(k) * LN2 + (sum <<< 1);
  endfunction

  // round(atanh(a/2048) * 1024) = round((ln(2048+a) - ln(2048-a)) / 2^19) in the 2^28 scale.
  function automatic logic [DATA_WIDTH-1:0] atanh_word(input int a);
    longint d;
    d = ln_fx(longint'(2048 + a)) - ln_fx(longint'(2048 - a));
    return DATA_WIDTH'((d + (longint'(1) <<< 18)) >>> 19);
  endfunction

  logic [DATA_WIDTH-1:0] rom [0:(1<<ADDR_WIDTH)-1];

  for (genvar a = 0; a < (1 << ADDR_WIDTH); a++) begin : g_rom
    localparam logic [DATA_WIDTH-1:0] WORD = atanh_word(a);
    assign rom[a] = WORD;
  end

  logic [15:0]           in1_q;
  logic                  v1_q;
  logic                  v2_q, tbl2_q, s2_q;
  logic [15:0]           word2_q;
  logic [DATA_WIDTH-1:0] rom_q;
  logic                  v3_q;
  logic [15:0]           res3_q;
  logic                  vo_q;
  logic [15:0]           out_q;

  logic                  tbl_d;
  logic [15:0]           word_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [15:0]           res3_d;
  logic [3:0]            lead_p;
  logic [DATA_WIDTH-1:0] aligned;

  always_comb begin
    tbl_d  = 1'b0;
    word_d = in1_q;
    addr_d = '0;
    if (in1_q[14:0] == 15'h0000) begin
      word_d = in1_q;
    end else if (in1_q[14:0] > 15'h3C00) begin
      word_d = 16'h7E00;
    end else if (in1_q[14:0] == 15'h3C00) begin
      word_d = {in1_q[15], 15'h7C00};
    end else if (in1_q[14:10] < 5'd10) begin
      word_d = in1_q;
    end else begin
      tbl_d  = 1'b1;
      // |x| * 2048 = 1.mant * 2^(e-4): exponents 10..14 give right shifts of 4..0
      addr_d = ADDR_WIDTH'({1'b1, in1_q[9:0]} >> (5'd14 - in1_q[14:10]));
    end
  end

  always_comb begin
    lead_p = 4'd0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (rom_q[i]) lead_p = 4'(i);
    end
    aligned = rom_q << (4'd12 - lead_p);
    res3_d  = tbl2_q ? {s2_q, 5'd5 + {1'b0, lead_p}, aligned[11:2]} : word2_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in1_q   <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      tbl2_q  <= 1'b0;
      s2_q    <= 1'b0;
      word2_q <= '0;
      rom_q   <= '0;
      v3_q    <= 1'b0;
      res3_q  <= '0;
      vo_q    <= 1'b0;
      out_q   <= '0;
    end else if (enable) begin
      in1_q   <= num_entrada;
      v1_q    <= in_valid;
      v2_q    <= v1_q;
      tbl2_q  <= tbl_d;
      s2_q    <= in1_q[15];
      word2_q <= word_d;
      rom_q   <= rom[addr_d];
      v3_q    <= v2_q;
      res3_q  <= res3_d;
      vo_q    <= v3_q;
      out_q   <= res3_q;
    end
  end

  assign out_valid  = vo_q;
  assign num_salida = out_q;

endmodule

// File: tb/tb_atanh_fp16_pipe.sv
// tb/tb_atanh_fp16_pipe.sv - directed and sweep checks for atanh_fp16_pipe
module tb_atanh_fp16_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        in_valid;
  logic [15:0] num_entrada;
  logic        out_valid;
  logic [15:0] num_salida;

  int checks = 0;
  int errors = 0;
  int rom_m [0:2047];

  always #5 clk = ~clk;

  atanh_fp16_pipe #(.ADDR_WIDTH(11), .DATA_WIDTH(13)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .in_valid   (in_valid),
    .num_entrada(num_entrada),
    .out_valid  (out_valid),
    .num_salida (num_salida)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    enable = 1'b1; in_valid = 1'b0; num_entrada = 16'h0000;
    repeat (4) tick();
  endtask

  task automatic push(input logic [15:0] x, output logic [15:0] y, output logic v);
    enable = 1'b1; in_valid = 1'b1; num_entrada = x;
    tick();
    in_valid = 1'b0; num_entrada = 16'h0000;
    repeat (3) tick();
    y = num_salida;
    v = out_valid;
  endtask

  function automatic logic [15:0] model(input logic [15:0] x);
    int  e, mant, addr, q, p;
    real val;
    e    = int'(x[14:10]);
    mant = int'(x[9:0]);
    if (x[14:0] == 15'h0000) return x;
    if (x[14:0] > 15'h3C00) return 16'h7E00;
    if (x[14:0] == 15'h3C00) return {x[15], 15'h7C00};
    if (e < 10) return x;
    val  = real'(1024 + mant) * (2.0 ** (e - 25));
    addr = int'($floor(val * 2048.0));
    q    = rom_m[addr];
    p    = 0;
    while ((1 << (p + 1)) <= q) p++;
    return {x[15], 5'(5 + p), 10'(((q - (1 << p)) * 1024) / (1 << p))};
  endfunction

  function automatic logic [15:0] sweep_src(input int idx);
    if (idx < 32768) return 16'(idx);
    return 16'h8000 | 16'((idx - 32768) * 16);
  endfunction

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; in_valid = 1'b0; num_entrada = 16'h0000;
    tick();
    checks++;
    if ({out_valid, num_salida} !== 17'h0_0000) begin
      errors++;
      $display("FAIL reset_no_enable got v=%b d=%h want v=0 d=0000", out_valid, num_salida);
    end
    enable = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({out_valid, num_salida} !== 17'h0_0000) begin
      errors++;
      $display("FAIL reset_state got v=%b d=%h want v=0 d=0000", out_valid, num_salida);
    end
  endtask

  task automatic test_table();
    logic [15:0] tin [3] = '{16'h3800, 16'hB800, 16'h3BFF};
    logic [15:0] texp[3] = '{16'h3864, 16'hB864, 16'h4428};
    logic [15:0] y;
    logic        v;
    for (int i = 0; i < 3; i++) begin
      push(tin[i], y, v);
      checks++;
      if ({v, y} !== {1'b1, texp[i]}) begin
        errors++;
        $display("FAIL table in=%h got v=%b d=%h want v=1 d=%h", tin[i], v, y, texp[i]);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [15:0] tin [7] = '{16'h3C00, 16'hBC00, 16'h3C01, 16'h7C00, 16'h7E00, 16'h8000, 16'h0000};
    logic [15:0] texp[7] = '{16'h7C00, 16'hFC00, 16'h7E00, 16'h7E00, 16'h7E00, 16'h8000, 16'h0000};
    logic [15:0] y;
    logic        v;
    for (int i = 0; i < 7; i++) begin
      push(tin[i], y, v);
      checks++;
      if ({v, y} !== {1'b1, texp[i]}) begin
        errors++;
        $display("FAIL boundary in=%h got v=%b d=%h want v=1 d=%h", tin[i], v, y, texp[i]);
      end
    end
  endtask

  task automatic test_bypass();
    logic [15:0] y;
    logic        v;
    push(16'h1000, y, v);
    checks++;
    if ({v, y} !== {1'b1, 16'h1000}) begin
      errors++;
      $display("FAIL bypass_1000 got v=%b d=%h want v=1 d=1000", v, y);
    end
    push(16'h27FF, y, v);
    checks++;
    if ({v, y} !== {1'b1, 16'h27FF}) begin
      errors++;
      $display("FAIL bypass_27ff got v=%b d=%h want v=1 d=27ff", v, y);
    end
    push(16'h2800, y, v);
    checks++;
    if (v !== 1'b1 || (y !== 16'h2800 && y !== 16'h2801 && y !== 16'h27FF)) begin
      errors++;
      $display("FAIL table_2800 got v=%b d=%h want v=1 d=2800+-1", v, y);
    end
  endtask

  task automatic stall2();
    logic [16:0] snap;
    snap = {out_valid, num_salida};
    enable = 1'b0; in_valid = 1'b1; num_entrada = 16'h3555;
    repeat (2) begin
      tick();
      checks++;
      if ({out_valid, num_salida} !== snap) begin
        errors++;
        $display("FAIL stall_hold got %h want %h", {out_valid, num_salida}, snap);
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_stall();
    logic [15:0] got[$];
    logic [15:0] sexp[3] = '{16'h3864, 16'h7C00, 16'h4428};
    drain();
    in_valid = 1'b1; num_entrada = 16'h3800; tick();
    if (out_valid) got.push_back(num_salida);
    num_entrada = 16'h3C00; tick();
    if (out_valid) got.push_back(num_salida);
    stall2();
    in_valid = 1'b1; num_entrada = 16'h3BFF; tick();
    if (out_valid) got.push_back(num_salida);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b0; num_entrada = 16'h0000;
      tick();
      if (out_valid) got.push_back(num_salida);
      if (i == 0) stall2();
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL stream_count got %0d want 3", got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== sexp[i]) begin
        errors++;
        $display("FAIL stream_order idx=%0d got %h want %h", i, got[i], sexp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int          ghost;
    logic [15:0] y;
    logic        v;
    drain();
    in_valid = 1'b1;
    num_entrada = 16'h3800; tick();
    num_entrada = 16'hB800; tick();
    num_entrada = 16'h3BFF; tick();
    reset = 1'b1; num_entrada = 16'h3C00;
    tick();
    reset = 1'b0; in_valid = 1'b0; num_entrada = 16'h0000;
    checks++;
    if ({out_valid, num_salida} !== 17'h0_0000) begin
      errors++;
      $display("FAIL reset_mid got v=%b d=%h want v=0 d=0000", out_valid, num_salida);
    end
    ghost = 0;
    repeat (6) begin
      tick();
      if (out_valid) ghost++;
    end
    checks++;
    if (ghost != 0) begin
      errors++;
      $display("FAIL reset_ghost got %0d pulses want 0", ghost);
    end
    push(16'h3800, y, v);
    checks++;
    if ({v, y} !== {1'b1, 16'h3864}) begin
      errors++;
      $display("FAIL after_reset got v=%b d=%h want v=1 d=3864", v, y);
    end
  endtask

  task automatic test_sweep();
    logic [15:0] expq[$];
    logic [15:0] inq[$];
    logic [15:0] e, x;
    int          idx, budget, shown, total;
    real         r;
    for (int a = 0; a < 2048; a++) begin
      r = real'(a) / 2048.0;
      rom_m[a] = int'($floor(0.5 * $ln((1.0 + r) / (1.0 - r)) * 1024.0 + 0.5));
    end
    drain();
    idx = 0; budget = 0; shown = 0; total = 32768 + 2048;
    while (budget < 95000 && (idx < total || expq.size() != 0)) begin
      enable   = ($urandom_range(3) != 0);
      in_valid = (idx < total) && ($urandom_range(7) != 0);
      x        = (idx < total) ? sweep_src(idx) : 16'h0000;
      num_entrada = x;
      tick();
      budget++;
      if (enable) begin
        if (in_valid) begin
          expq.push_back(model(x));
          inq.push_back(x);
          idx++;
        end
        if (out_valid) begin
          checks++;
          if (expq.size() == 0) begin
            errors++;
            if (shown < 8) $display("FAIL sweep_extra got d=%h want no out_valid", num_salida);
            shown++;
          end else begin
            e = expq.pop_front();
            x = inq.pop_front();
            if (num_salida !== e) begin
              errors++;
              if (shown < 8) $display("FAIL sweep in=%h got %h want %h", x, num_salida, e);
              shown++;
            end
          end
        end
      end
    end
    checks++;
    if (idx != total || expq.size() != 0) begin
      errors++;
      $display("FAIL sweep_complete fed %0d of %0d, %0d results missing", idx, total, expq.size());
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; in_valid = 1'b0; num_entrada = 16'h0000;
    test_reset();
    test_table();
    test_boundaries();
    test_bypass();
    test_stall();
    test_reset_mid();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
